// File: rtl/serial_adder.sv
// serial_adder -- multi-cycle ripple adder that processes BITS_PER_CYCLE bits
// of the operands per clock, LSB chunk first.
//
// Parameters:
//   WIDTH          operand/result width in bits (>= 2)
//   BITS_PER_CYCLE chunk width added per clock; WIDTH must be a multiple of it
//
// Ports:
//   clk    single clock, rising edge
//   rst    synchronous active-high reset
//   start  begin an addition (sampled only in IDLE)
//   a, b   unsigned operands, latched on the accepted start edge
//   cin    carry-in, latched with the operands
//   busy   high while an addition is running or completing
//   done   one-cycle completion pulse
//   sum    registered result, modulo 2^WIDTH
//   carry  registered carry out of the MSB
//   ovf    (only with SERIAL_ADDER_OVF_EN defined) signed overflow of a+b+cin
//
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the ovf output.
//
// A start accepted at edge k produces done between edges k+N and k+N+1,
// where N = WIDTH/BITS_PER_CYCLE; holding start high gives one result every
// N+2 cycles.
module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int BPC   = BITS_PER_CYCLE;
  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_chunk;

  // Operand shift registers: the low chunk is always the one being added.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  // Partial sum accumulates here so sum only changes on completion.
  logic [WIDTH-1:0] sr_q;

  logic [BPC:0]         chunk_res;
  logic [WIDTH+BPC-1:0] sr_cat;
  logic [WIDTH-1:0]     sr_shift;

`ifdef SERIAL_ADDER_OVF_EN
  logic a_sgn;
  logic b_sgn;
`endif

  function automatic logic [BPC:0] add_chunk(input logic [BPC-1:0] x,
                                             input logic [BPC-1:0] y,
                                             input logic           ci);
    return {1'b0, x} + {1'b0, y} + {{BPC{1'b0}}, ci};
  endfunction

  assign chunk_res  = add_chunk(a_q[BPC-1:0], b_q[BPC-1:0], carry_q);
  // New chunk enters at the top; after N shifts the first chunk sits at the LSB.
  assign sr_cat     = {chunk_res[BPC-1:0], sr_q};
  assign sr_shift   = sr_cat[WIDTH+BPC-1:BPC];
  assign last_chunk = (cnt == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_chunk) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt     <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            a_sgn   <= a[WIDTH-1];
            b_sgn   <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_q     <= a_q >> BPC;
          b_q     <= b_q >> BPC;
          carry_q <= chunk_res[BPC];
          sr_q    <= sr_shift;
          cnt     <= cnt + 1'b1;
          if (last_chunk) begin
            cnt   <= '0;
            sum   <= sr_shift;
            carry <= chunk_res[BPC];
`ifdef SERIAL_ADDER_OVF_EN
            // Same-sign operands whose result sign differs overflowed.
            ovf   <= (a_sgn == b_sgn) && (sr_shift[WIDTH-1] != a_sgn);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start1;
  logic         start4;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy1, done1, carry1;
  logic         busy4, done4, carry4;
  logic [W-1:0] sum1, sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf1, ovf4;
`endif

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  serial_adder #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .cin(cin),
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    int           cyc0;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int   ndone1 = 0;
  int   ndone4 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Result monitors: pop the expected record on each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (done1 === 1'b1) begin
      ndone1++;
      if (q1.size() == 0) begin
        check("dut1_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        check("dut1_sum", 32'(sum1), 32'(e.sum));
        check("dut1_carry", 32'(carry1), 32'(e.carry));
        check("dut1_latency", 32'(cyc - e.cyc0), 32'd8);
`ifdef SERIAL_ADDER_OVF_EN
        check("dut1_ovf", 32'(ovf1), 32'(e.ovf));
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done4 === 1'b1) begin
      ndone4++;
      if (q4.size() == 0) begin
        check("dut4_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q4.pop_front();
        check("dut4_sum", 32'(sum4), 32'(e.sum));
        check("dut4_carry", 32'(carry4), 32'(e.carry));
        check("dut4_latency", 32'(cyc - e.cyc0), 32'd2);
`ifdef SERIAL_ADDER_OVF_EN
        check("dut4_ovf", 32'(ovf4), 32'(e.ovf));
`endif
      end
    end
  end

  // Called #1 after an edge with both DUTs idle.
  task automatic launch(input vec_t v, input logic go1, input logic go4);
    exp_t e;
    a = v.a; b = v.b; cin = v.cin;
    start1 = go1; start4 = go4;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    e.sum = v.sum; e.carry = v.carry; e.ovf = v.ovf; e.cyc0 = cyc;
    if (go1) q1.push_back(e);
    if (go4) q4.push_back(e);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("result_timeout", 32'(q1.size() + q4.size()), 32'd0);
  endtask

  initial begin
    vec_t tbl[8];
    vec_t v;
    exp_t e;
    int   d0;
    int   k;
    int   lows;

    tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[6] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};

    // Reset with start asserted: reset must win.
    rst = 1'b1; start1 = 1'b1; start4 = 1'b1;
    a = 8'hA5; b = 8'h5A; cin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_sum1", 32'(sum1), 32'd0);
    check("rst_carry1", 32'(carry1), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_sum4", 32'(sum4), 32'd0);
    rst = 1'b0; start1 = 1'b0; start4 = 1'b0;
    @(posedge clk); #1;

    // Table vectors on both chunk widths.
    for (int i = 0; i < 8; i++) begin
      launch(tbl[i], 1'b1, 1'b1);
      wait_empty();
      @(posedge clk); #1;
      check("dut1_hold_sum", 32'(sum1), 32'(tbl[i].sum));
      check("dut4_hold_sum", 32'(sum4), 32'(tbl[i].sum));
      check("dut1_idle_busy", 32'(busy1), 32'd0);
    end

    // Operand changes and a stray start during RUN are ignored.
    v = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    d0 = ndone1;
    launch(v, 1'b1, 1'b0);
    a = 8'hFF; b = 8'hFF; cin = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("dut1_midrun_sum_hidden", 32'(sum1), 32'h80);
    wait_empty();
    repeat (12) @(posedge clk);
    #1;
    check("dut1_single_done", 32'(ndone1 - d0), 32'd1);

    // Reset three cycles into RUN aborts with no done pulse.
    d0 = ndone1;
    a = 8'hFF; b = 8'h01; cin = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(busy1), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy1), 32'd0);
    check("abort_sum", 32'(sum1), 32'd0);
    check("abort_carry", 32'(carry1), 32'd0);
    check("abort_done", 32'(done1), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done", 32'(ndone1 - d0), 32'd0);
    launch(tbl[2], 1'b1, 1'b0);
    wait_empty();

    // Start held high: one result every 10 cycles, one idle cycle between.
    @(posedge clk); #1;
    d0 = ndone1;
    a = 8'h3C; b = 8'h0F; cin = 1'b1;
    start1 = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    for (int j = 0; j < 3; j++) begin
      e.sum = 8'h4C; e.carry = 1'b0; e.ovf = 1'b0; e.cyc0 = k + 10 * j;
      q1.push_back(e);
    end
    lows = 0;
    repeat (28) begin
      @(posedge clk); #1;
      if (busy1 === 1'b0) lows++;
    end
    @(posedge clk); #1;
    start1 = 1'b0;
    wait_empty();
    check("b2b_busy_low_cycles", 32'(lows), 32'd2);
    check("b2b_done_count", 32'(ndone1 - d0), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
